uart_stat_requester: RTL and testbench
======================================

Name: uart_stat_requester

Overview:
- Host-side requester for the UART statistics protocol: sends a one-byte command and collects the 2-byte big-endian reply (e.g. 'R' returns the frame counter).
- Sits between a controller (test harness, or a second board acting as host) and the `uart_top` byte interface.
- Provides a per-byte reply timeout and a stray-byte counter.

Parameters:
- TIMEOUT_CYCLES, 270000, clk cycles allowed before each reply byte arrives (10 ms at 27 MHz); minimum 2.
- TMR_W, 20, width of the timeout counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (27 MHz)
- rst  in  1  synchronous reset, active-high
- req_start  in  1  one-cycle request strobe; honoured only when busy=0
- req_cmd  in  8  command byte, sampled on an accepted req_start
- tx_data  out  8  byte to uart_top transmitter
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter accepts tx_data on a cycle with tx_valid=1 and tx_ready=1
- rx_data  in  8  received byte from uart_top
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- busy  out  1  high from the cycle after an accepted req_start until return to IDLE
- resp_data  out  16  reply {first byte, second byte}; holds its value until the next good reply
- resp_valid  out  1  one-cycle pulse: resp_data updated
- resp_timeout  out  1  one-cycle pulse: reply byte missing, transaction aborted
- stray_count  out  8  count of rx_valid bytes received outside a WAIT state; saturates at 255

Behaviour:
- Reset (synchronous; takes priority even mid-transaction): state=IDLE; tx_valid=0; tx_data=0; busy=0; resp_data=0; resp_valid=0; resp_timeout=0; stray_count=0; timer=0.
- States: IDLE, SEND, WAIT_HI, WAIT_LO. All outputs are registered.
- IDLE:
  - req_start=1 → latch req_cmd into tx_data; set tx_valid=1 and busy=1 at the next edge; go to SEND.
  - Latency: req_start at cycle N → tx_valid=1 at cycle N+1.
- SEND:
  - tx_valid=1; tx_data is stable.
  - tx_ready=1 → tx_valid=0 at the next edge; timer=0; go to WAIT_HI.
  - No timeout applies in SEND; the block waits indefinitely for tx_ready.
- WAIT_HI:
  - rx_valid=1 → store rx_data as the high byte; timer=0; go to WAIT_LO.
  - Otherwise timer increments. In the cycle where timer == TIMEOUT_CYCLES-1 with no rx_valid: pulse resp_timeout at the next edge; go to IDLE; busy=0.
- WAIT_LO:
  - rx_valid=1 → resp_data <= {high byte, rx_data}; pulse resp_valid at the next edge; go to IDLE; busy=0.
  - Timeout rule is the same as in WAIT_HI; resp_data is left unchanged.
- rx_valid and timer expiry in the same cycle: the byte wins and no timeout occurs.
- rx_valid in IDLE or SEND: the byte is discarded and stray_count increments (holds at 255).
- req_start while busy=1, or in the same cycle busy falls: ignored, no queueing. A new request is accepted in IDLE from the cycle after resp_valid or resp_timeout.
- resp_valid and resp_timeout are mutually exclusive, and each is a pulse of exactly one cycle.
- Reset mid-SEND: tx_valid drops at that edge; the command byte is abandoned.

Test Plan (bench uses TIMEOUT_CYCLES=100):
- Nominal: req_start with req_cmd=8'h52; tx_ready=1 two cycles after tx_valid rises; rx bytes 8'h12 then 8'h34 → tx_data=8'h52 held until accepted; resp_data=16'h1234; resp_valid high for 1 cycle; busy low afterwards.
- Backpressure: tx_ready low for 50 cycles → tx_valid and tx_data=8'h52 stay constant; no timeout; completes normally afterwards.
- Timeout: command accepted, no rx → resp_timeout pulses 100 cycles after entering WAIT_HI; resp_data keeps its previous 16'h1234. Repeat with a single byte 8'hAA followed by silence → timeout 100 cycles after that byte.
- Boundary: rx_valid coincides with the final timeout cycle → byte accepted, no resp_timeout pulse.
- Stray/busy: 3 rx bytes in IDLE, then 300 more → stray_count=3, then saturates at 255. req_start pulsed during WAIT_HI → ignored, and only one command is transmitted.
- Reset mid-WAIT_LO: rst for 1 cycle → all outputs at reset values; next request with reply 8'h00, 8'hFF gives resp_data=16'h00FF.

Source files
------------

// File: rtl/uart_stat_requester_if.sv
// Byte-level channel between the stats requester and the uart_top transmitter/receiver.
interface uart_stat_requester_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/uart_stat_requester.sv
// Host-side requester for the UART statistics protocol: sends one command byte and
// collects a 2-byte big-endian reply, with a per-byte timeout and a stray-byte counter.
module uart_stat_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 270000,
    parameter int unsigned TMR_W          = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_start,
    input  logic [7:0]                    req_cmd,
    uart_stat_requester_if.master         uart,
    output logic                          busy,
    output logic [15:0]                   resp_data,
    output logic                          resp_valid,
    output logic                          resp_timeout,
    output logic [7:0]                    stray_count
);

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [BYTE_W-1:0] hi_byte;
    logic [BYTE_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              expired_c;
    logic              stray_c;

    assign uart.tx_data  = tx_data_q;
    assign uart.tx_valid = tx_valid_q;

    // Last permitted cycle of the reply window for the current byte.
    assign expired_c = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign stray_c   = uart.rx_valid && ((state == IDLE) || (state == SEND));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            hi_byte      <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy         <= 1'b0;
            resp_data    <= '0;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            stray_count  <= '0;
        end else begin
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;

            // Bytes nobody asked for are dropped but counted, saturating.
            if (stray_c && (stray_count != 8'hFF)) begin
                stray_count <= stray_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (req_start) begin
                        tx_data_q  <= req_cmd;
                        tx_valid_q <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end

                SEND: begin
                    if (uart.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        timer      <= '0;
                        state      <= WAIT_HI;
                    end
                end

                WAIT_HI: begin
                    if (uart.rx_valid) begin
                        hi_byte <= uart.rx_data;
                        timer   <= '0;
                        state   <= WAIT_LO;
                    end else if (expired_c) begin
                        resp_timeout <= 1'b1;
                        busy         <= 1'b0;
                        timer        <= '0;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                WAIT_LO: begin
                    if (uart.rx_valid) begin
                        resp_data  <= {hi_byte, uart.rx_data};
                        resp_valid <= 1'b1;
                        busy       <= 1'b0;
                        timer      <= '0;
                        state      <= IDLE;
                    end else if (expired_c) begin
                        resp_timeout <= 1'b1;
                        busy         <= 1'b0;
                        timer        <= '0;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_stat_requester.sv
// Self-checking bench for uart_stat_requester with a response scoreboard and a short reply timeout.
module tb_uart_stat_requester;

    localparam int unsigned TO = 100;

    typedef struct {
        logic        is_to;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_start;
    logic [7:0]  req_cmd;
    logic        busy;
    logic [15:0] resp_data;
    logic        resp_valid;
    logic        resp_timeout;
    logic [7:0]  stray_count;

    uart_stat_requester_if u_if ();

    uart_stat_requester #(
        .TIMEOUT_CYCLES(TO),
        .TMR_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_start   (req_start),
        .req_cmd     (req_cmd),
        .uart        (u_if),
        .busy        (busy),
        .resp_data   (resp_data),
        .resp_valid  (resp_valid),
        .resp_timeout(resp_timeout),
        .stray_count (stray_count)
    );

    exp_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   cyc         = 0;
    int   hs_cyc      = 0;
    int   tx_count    = 0;
    int   resp_events = 0;
    int   resp_cyc    = 0;
    logic prev_pulse  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter and transmitter handshake monitor.
    always @(posedge clk) begin
        cyc++;
        if (!rst && u_if.tx_valid && u_if.tx_ready) begin
            tx_count++;
            hs_cyc = cyc;
        end
    end

    // Response scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic pulse;
        exp_t e;
        pulse = resp_valid || resp_timeout;
        if (prev_pulse) begin
            checks++;
            if (pulse) begin
                errors++;
                $display("FAIL pulse_width: response strobe high on two consecutive cycles at cycle %0d", cyc);
            end
        end
        if (pulse) begin
            resp_events++;
            resp_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got valid=%0b timeout=%0b data=%h with nothing expected",
                         resp_valid, resp_timeout, resp_data);
            end else begin
                e = exp_q.pop_front();
                if ({resp_timeout, resp_valid, resp_data} !== {e.is_to, ~e.is_to, e.data}) begin
                    errors++;
                    $display("FAIL scoreboard: got timeout=%0b valid=%0b data=%h, expected timeout=%0b valid=%0b data=%h",
                             resp_timeout, resp_valid, resp_data, e.is_to, ~e.is_to, e.data);
                end
            end
        end
        prev_pulse = pulse;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic is_to, input logic [15:0] data);
        exp_t e;
        e.is_to = is_to;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic start_req(input logic [7:0] cmd);
        req_start = 1'b1;
        req_cmd   = cmd;
        tick();
        req_start = 1'b0;
    endtask

    task automatic handshake();
        u_if.tx_ready = 1'b1;
        tick();
        u_if.tx_ready = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        u_if.rx_valid = 1'b1;
        u_if.rx_data  = b;
        tick();
        u_if.rx_valid = 1'b0;
    endtask

    task automatic wait_resp(input int max_cycles, input string name);
        int s;
        s = resp_events;
        for (int i = 0; i < max_cycles && resp_events == s; i++) tick();
        checks++;
        if (resp_events == s) begin
            errors++;
            $display("FAIL %s: no response within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({u_if.tx_valid, u_if.tx_data, busy, resp_data, resp_valid, resp_timeout, stray_count} !== '0) begin
            errors++;
            $display("FAIL %s: tx_valid=%0b tx_data=%h busy=%0b resp_data=%h rv=%0b rt=%0b stray=%0d, required all zero",
                     name, u_if.tx_valid, u_if.tx_data, busy, resp_data, resp_valid, resp_timeout, stray_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic test_nominal();
        int  n0;
        logic bad;
        n0 = tx_count;
        start_req(8'h52);
        checks++;
        if ({u_if.tx_valid, u_if.tx_data, busy} !== {1'b1, 8'h52, 1'b1}) begin
            errors++;
            $display("FAIL nominal_accept: tx_valid=%0b tx_data=%h busy=%0b, required 1 52 1",
                     u_if.tx_valid, u_if.tx_data, busy);
        end
        bad = 1'b0;
        repeat (2) begin
            tick();
            if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== 8'h52) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL nominal_hold: tx_valid/tx_data not held, now %0b %h", u_if.tx_valid, u_if.tx_data);
        end
        handshake();
        checks++;
        if ({u_if.tx_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL nominal_sent: tx_valid=%0b busy=%0b, required 0 1", u_if.tx_valid, busy);
        end
        push_exp(1'b0, 16'h1234);
        send_rx(8'h12);
        send_rx(8'h34);
        checks++;
        if ({resp_valid, busy, resp_data} !== {1'b1, 1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL nominal_resp: resp_valid=%0b busy=%0b resp_data=%h, required 1 0 1234",
                     resp_valid, busy, resp_data);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || tx_count - n0 != 1) begin
            errors++;
            $display("FAIL nominal_end: resp_valid=%0b tx_sent=%0d, required 0 1", resp_valid, tx_count - n0);
        end
    endtask

    task automatic test_backpressure();
        int   ev0;
        logic bad;
        ev0 = resp_events;
        start_req(8'h52);
        bad = 1'b0;
        repeat (50) begin
            tick();
            if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== 8'h52 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad || resp_events != ev0) begin
            errors++;
            $display("FAIL backpressure_hold: tx_valid=%0b tx_data=%h events=%0d, required 1 52 0",
                     u_if.tx_valid, u_if.tx_data, resp_events - ev0);
        end
        handshake();
        push_exp(1'b0, 16'h1234);
        send_rx(8'h12);
        send_rx(8'h34);
        tick();
        checks++;
        if (resp_events - ev0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_done: events=%0d busy=%0b, required 1 0", resp_events - ev0, busy);
        end
    endtask

    task automatic test_timeout();
        int rx_cyc;
        push_exp(1'b1, 16'h1234);
        start_req(8'h52);
        handshake();
        wait_resp(TO + 20, "timeout_hi_wait");
        checks++;
        if (resp_cyc - hs_cyc != TO || resp_data !== 16'h1234 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hi: delay=%0d data=%h busy=%0b, required %0d 1234 0",
                     resp_cyc - hs_cyc, resp_data, busy, TO);
        end
        tick();
        push_exp(1'b1, 16'h1234);
        start_req(8'h52);
        handshake();
        send_rx(8'hAA);
        rx_cyc = cyc;
        wait_resp(TO + 20, "timeout_lo_wait");
        checks++;
        if (resp_cyc - rx_cyc != TO || resp_data !== 16'h1234) begin
            errors++;
            $display("FAIL timeout_lo: delay=%0d data=%h, required %0d 1234", resp_cyc - rx_cyc, resp_data, TO);
        end
        tick();
    endtask

    task automatic test_boundary();
        int ev0;
        int b_cyc;
        ev0 = resp_events;
        push_exp(1'b0, 16'hABCD);
        start_req(8'h52);
        handshake();
        repeat (TO - 1) tick();
        send_rx(8'hAB);
        b_cyc = cyc;
        repeat (TO - 1) tick();
        send_rx(8'hCD);
        checks++;
        if (resp_events - ev0 != 1 || resp_cyc != b_cyc + int'(TO) || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL boundary: events=%0d resp_cycle=%0d valid=%0b, required 1 %0d 1",
                     resp_events - ev0, resp_cyc, resp_valid, b_cyc + int'(TO));
        end
        tick();
    endtask

    task automatic test_stray();
        int n0;
        repeat (3) send_rx(8'h55);
        checks++;
        if (stray_count !== 8'd3) begin
            errors++;
            $display("FAIL stray_3: stray_count=%0d, required 3", stray_count);
        end
        repeat (300) send_rx(8'h66);
        tick();
        checks++;
        if (stray_count !== 8'd255) begin
            errors++;
            $display("FAIL stray_sat: stray_count=%0d, required 255", stray_count);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = tx_count;
        start_req(8'h52);
        handshake();
        req_start = 1'b1;
        req_cmd   = 8'h99;
        tick();
        req_start = 1'b0;
        checks++;
        if ({u_if.tx_valid, busy, u_if.tx_data} !== {1'b0, 1'b1, 8'h52}) begin
            errors++;
            $display("FAIL busy_ignore: tx_valid=%0b busy=%0b tx_data=%h, required 0 1 52",
                     u_if.tx_valid, busy, u_if.tx_data);
        end
        push_exp(1'b0, 16'h0102);
        send_rx(8'h01);
        // Request coincides with the final reply byte: busy falls there, request dropped.
        req_start     = 1'b1;
        req_cmd       = 8'h77;
        u_if.rx_valid = 1'b1;
        u_if.rx_data  = 8'h02;
        tick();
        req_start     = 1'b0;
        u_if.rx_valid = 1'b0;
        tick();
        checks++;
        if ({u_if.tx_valid, busy} !== 2'b00 || tx_count - n0 != 1) begin
            errors++;
            $display("FAIL fall_ignore: tx_valid=%0b busy=%0b tx_sent=%0d, required 0 0 1",
                     u_if.tx_valid, busy, tx_count - n0);
        end
    endtask

    task automatic test_reset_mid();
        start_req(8'h52);
        handshake();
        send_rx(8'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("reset_mid_wait_lo");
        start_req(8'h33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("reset_mid_send");
        push_exp(1'b0, 16'h00FF);
        start_req(8'h52);
        handshake();
        send_rx(8'h00);
        send_rx(8'hFF);
        checks++;
        if (resp_data !== 16'h00FF || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: resp_data=%h busy=%0b, required 00ff 0", resp_data, busy);
        end
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        req_start     = 1'b0;
        req_cmd       = 8'h00;
        u_if.tx_ready = 1'b0;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'h00;
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_boundary();
        test_back_to_back();
        test_stray();
        test_reset_mid();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected responses never arrived", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
